// File: rtl/nco_lfo_ctrl.sv
// Rate divider and start/stop sequencer for the triangle LFO NCO; mod/mod_vld follow nco_nxt by one clock.
// Stopping drains the wave to zero before dropping nco_en; cfg is valid/ready with one pending slot.
module nco_lfo_ctrl #(
  parameter int N       = 8,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             smp_tick,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_vld,
  output logic             cfg_rdy,
  output logic             nco_en,
  output logic             nco_nxt,
  input  logic [N-1:0]     nco_wav,
  output logic [N-1:0]     mod,
  output logic             mod_vld,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_q, cnt, pend;
  logic             pend_vld;
  logic             nxt_q;
  logic [N-1:0]     mod_q;
  logic             active, wrap, cfg_acc, going_idle;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = RUN;
      RUN:     if (!run) state_nxt = DRAIN;
      DRAIN: begin
        if (run)                         state_nxt = RUN;
        else if (mod_vld && mod == '0)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign active     = (state != IDLE);
  assign wrap       = active && smp_tick && (cnt == div_q);
  assign going_idle = active && (state_nxt == IDLE);
  assign cfg_rdy    = rst && !pend_vld;
  assign cfg_acc    = cfg_vld && cfg_rdy;
  assign nco_en     = active;
  assign busy       = active;
  // A step already in flight when the wave hits zero is dropped so the NCO stops exactly at zero.
  assign nco_nxt    = nxt_q && !going_idle;
  // The NCO has just stepped during the strobe cycle, so mod shows the fresh wave and then holds it.
  assign mod        = mod_vld ? nco_wav : mod_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q    <= DIV_W'(DEF_DIV);
      cnt      <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      nxt_q    <= 1'b0;
      mod_q    <= '0;
      mod_vld  <= 1'b0;
    end else begin
      nxt_q   <= wrap && !going_idle;
      mod_vld <= nco_nxt;
      if (mod_vld) mod_q <= nco_wav;

      if (!active)       cnt <= '0;
      else if (smp_tick) cnt <= wrap ? '0 : cnt + DIV_W'(1);

      // Divider changes only land on a period boundary, or immediately when the divider is idle.
      if (!active || going_idle) begin
        if (pend_vld) begin
          div_q    <= pend;
          pend_vld <= 1'b0;
        end else if (cfg_acc) begin
          div_q <= cfg_div;
        end
      end else begin
        if (wrap && pend_vld) begin
          div_q    <= pend;
          pend_vld <= 1'b0;
        end else if (cfg_acc) begin
          pend     <= cfg_div;
          pend_vld <= 1'b1;
        end
      end
    end
  end

endmodule
